// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated edge counter measuring the frequency of an asynchronous input
module freq_meter #(
    parameter int CLK_FREQ  = 100000000,
    parameter int GATE_RATE = 1,
    parameter int CNT_BITS  = 28
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                sig_in,
    input  logic                enable,
    output logic [CNT_BITS-1:0] freq_count,
    output logic                valid,
    output logic                overflow,
    output logic                busy
);

    localparam int GATE_CYCLES = CLK_FREQ / GATE_RATE;
    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t state, state_next;

    logic                sync1, sync2, hist;
    logic [1:0]          prime_cnt;
    logic                primed;
    logic                rise;
    logic [GW-1:0]       gate_cnt;
    logic [CNT_BITS-1:0] edge_cnt;
    logic                ovf;
    logic                terminal;
    logic                at_max;

    // The synchronizer powers up cleared, so a high sig_in at reset release looks
    // like a rising edge; the first three cycles are masked to hide it.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            hist      <= 1'b0;
            prime_cnt <= 2'd0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            hist  <= sync2;
            if (!primed) begin
                prime_cnt <= prime_cnt + 2'd1;
            end
        end
    end

    assign primed   = (prime_cnt == 2'd3);
    assign rise     = sync2 & ~hist & primed;
    assign terminal = (state == MEASURE) && (gate_cnt == GATE_LAST);
    assign at_max   = (edge_cnt == CNT_MAX);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable)  state_next = MEASURE;
            MEASURE: if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf        <= 1'b0;
            freq_count <= '0;
            valid      <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid <= 1'b0;
            busy  <= (state_next == MEASURE);
            if (terminal) begin
                // Terminal-cycle edge is folded in so back-to-back windows lose nothing.
                freq_count <= (rise && at_max) ? CNT_MAX
                                               : edge_cnt + {{(CNT_BITS-1){1'b0}}, rise};
                overflow   <= ovf | (rise & at_max);
                valid      <= 1'b1;
                gate_cnt   <= '0;
                edge_cnt   <= '0;
                ovf        <= 1'b0;
            end else if (state == MEASURE && enable) begin
                gate_cnt <= gate_cnt + GW'(1);
                if (rise) begin
                    if (at_max) begin
                        ovf <= 1'b1;
                    end else begin
                        edge_cnt <= edge_cnt + CNT_BITS'(1);
                    end
                end
            end else begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                ovf      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - scoreboard bench for freq_meter
module tb_freq_meter;

    typedef struct {
        int cnt;
        bit ovf;
        bit busy;
        int cyc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        sig_a, sig_b;
    logic        en_a, en_b;
    logic [27:0] freq_a;
    logic [3:0]  freq_b;
    logic        valid_a, valid_b, ovf_a, ovf_b, busy_a, busy_b;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   mode_a = 0;
    int   mode_b = 0;
    exp_t qa[$];
    exp_t qb[$];

    freq_meter #(.CLK_FREQ(1000), .GATE_RATE(1), .CNT_BITS(28)) dut_a (
        .clk_in(clk), .reset(reset), .sig_in(sig_a), .enable(en_a),
        .freq_count(freq_a), .valid(valid_a), .overflow(ovf_a), .busy(busy_a)
    );

    freq_meter #(.CLK_FREQ(1000), .GATE_RATE(1), .CNT_BITS(4)) dut_b (
        .clk_in(clk), .reset(reset), .sig_in(sig_b), .enable(en_b),
        .freq_count(freq_b), .valid(valid_b), .overflow(ovf_b), .busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // mode 0 = low, 1 = high, 2 = square wave of period 10
    initial begin
        int ph;
        ph    = 0;
        sig_a = 1'b0;
        sig_b = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ph    = (ph == 9) ? 0 : ph + 1;
            sig_a = (mode_a == 2) ? (ph < 5) : (mode_a == 1);
            sig_b = (mode_b == 2) ? (ph < 5) : (mode_b == 1);
        end
    end

    always @(negedge clk) begin
        if (valid_a) begin
            if (qa.size() == 0) begin
                check("a_spurious_valid", valid_a, 0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_count", freq_a, e.cnt);
                check("a_overflow", ovf_a, e.ovf);
                check("a_busy", busy_a, e.busy);
                check("a_valid_cycle", cyc, e.cyc);
            end
        end
        if (valid_b) begin
            if (qb.size() == 0) begin
                check("b_spurious_valid", valid_b, 0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_count", freq_b, e.cnt);
                check("b_overflow", ovf_b, e.ovf);
                check("b_busy", busy_b, e.busy);
                check("b_valid_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((qa.size() + qb.size()) != 0 && k < 2500) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(tag, qa.size() + qb.size(), 0);
    endtask

    // Run n contiguous windows on dut_a, dropping enable in the last terminal cycle.
    task automatic measure(input int n, input int cnt, input bit ovf, input string tag);
        int t;
        t    = cyc;
        en_a = 1'b1;
        for (int i = 0; i < n; i++) begin
            qa.push_back('{cnt: cnt, ovf: ovf, busy: (i < n - 1), cyc: t + 1001 + 1000 * i});
        end
        wait_cyc(t + 1000 * n);
        en_a = 1'b0;
        drain(tag);
    endtask

    initial begin
        int t;
        reset  = 1'b1;
        en_a   = 1'b0;
        en_b   = 1'b0;
        mode_a = 1;
        mode_b = 2;

        wait_cyc(3);
        @(negedge clk);
        check("reset_freq_count", freq_a, 0);
        check("reset_valid", valid_a, 0);
        check("reset_overflow", ovf_a, 0);
        check("reset_busy", busy_a, 0);

        // sig_in high across reset release, enable in the first cycle out of reset
        wait_cyc(5);
        reset = 1'b0;
        measure(1, 0, 0, "held_high_drain");

        mode_a = 0;
        wait_cyc(cyc + 20);
        measure(1, 0, 0, "held_low_drain");

        mode_a = 2;
        wait_cyc(cyc + 20);
        measure(3, 100, 0, "continuous_drain");

        // abort at window cycle 500
        t    = cyc;
        en_a = 1'b1;
        wait_cyc(t + 501);
        check("abort_busy_before", busy_a, 1);
        en_a = 1'b0;
        wait_cyc(t + 502);
        @(negedge clk);
        check("abort_busy_after", busy_a, 0);
        check("abort_count_kept", freq_a, 100);
        wait_cyc(t + 1700);
        check("abort_count_still", freq_a, 100);

        // reset at window cycle 700
        t    = cyc;
        en_a = 1'b1;
        wait_cyc(t + 701);
        reset = 1'b1;
        en_a  = 1'b0;
        wait_cyc(t + 702);
        @(negedge clk);
        check("midreset_freq_count", freq_a, 0);
        check("midreset_valid", valid_a, 0);
        check("midreset_overflow", ovf_a, 0);
        check("midreset_busy", busy_a, 0);
        wait_cyc(t + 703);
        reset = 1'b0;
        wait_cyc(cyc + 20);
        measure(1, 100, 0, "after_reset_drain");

        // narrow counter saturates, then a silent window clears overflow
        t    = cyc;
        en_b = 1'b1;
        qb.push_back('{cnt: 15, ovf: 1'b1, busy: 1'b1, cyc: t + 1001});
        qb.push_back('{cnt: 0, ovf: 1'b0, busy: 1'b0, cyc: t + 2001});
        wait_cyc(t + 900);
        mode_b = 0;
        wait_cyc(t + 2000);
        en_b = 1'b0;
        drain("saturate_drain");

        wait_cyc(cyc + 50);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: stuck at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
